// File: rtl/spi_obi_pkg.sv
// Shared widths and FSM state encoding for the SPI-slave OBI master.
package spi_obi_pkg;
  localparam int unsigned WORD_BYTES = 4;
  localparam int unsigned OBI_AW     = 32;
  localparam int unsigned OBI_DW     = 32;
  localparam int unsigned OBI_BEW    = OBI_DW / 8;
  localparam int unsigned WRAP_W     = 16;
  localparam int unsigned WORD_SHIFT = $clog2(WORD_BYTES);
  localparam int unsigned CNT_W      = OBI_AW - WORD_SHIFT;

  typedef enum logic [2:0] {
    IDLE,
    WR_WAIT,
    WR_REQ,
    WR_RESP,
    RD_REQ,
    RD_RESP,
    RD_HOLD
  } state_e;
endpackage

// File: rtl/spi_slave_obi_master_if.sv
// OBI request/response bundle between the SPI burst engine and the memory side.
interface spi_slave_obi_master_if;
  import spi_obi_pkg::*;

  logic               obi_req;
  logic               obi_gnt;
  logic [OBI_AW-1:0]  obi_addr;
  logic               obi_we;
  logic [OBI_BEW-1:0] obi_be;
  logic [OBI_DW-1:0]  obi_wdata;
  logic               obi_rvalid;
  logic [OBI_DW-1:0]  obi_rdata;
  logic               obi_err;

  modport master (
    output obi_req, obi_addr, obi_we, obi_be, obi_wdata,
    input  obi_gnt, obi_rvalid, obi_rdata, obi_err
  );

  modport slave (
    input  obi_req, obi_addr, obi_we, obi_be, obi_wdata,
    output obi_gnt, obi_rvalid, obi_rdata, obi_err
  );
endinterface

// File: rtl/spi_obi_addr_gen.sv
// Burst address generator: base + WORD_BYTES*count, count optionally wrapping at wrap length.
module spi_obi_addr_gen
  import spi_obi_pkg::*;
(
  input  logic              sys_clk,
  input  logic              sys_rstn,
  input  logic              load,
  input  logic              advance,
  input  logic [OBI_AW-1:0] start_addr,
  input  logic [WRAP_W-1:0] wrap_len,
  output logic [OBI_AW-1:0] addr
);
  logic [OBI_AW-1:0] base_q, base_d;
  logic [OBI_AW-1:0] addr_q, addr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [WRAP_W-1:0] wrap_q, wrap_d;
  logic              wrap_hit;

  // Address is registered from the next-state count so it is valid with the request.
  always_comb begin
    base_d   = base_q;
    count_d  = count_q;
    wrap_d   = wrap_q;
    wrap_hit = (wrap_q != '0) && (count_q == CNT_W'(wrap_q - WRAP_W'(1)));
    if (load) begin
      base_d  = start_addr;
      count_d = '0;
      wrap_d  = wrap_len;
    end else if (advance) begin
      count_d = wrap_hit ? '0 : count_q + CNT_W'(1);
    end
    addr_d = base_d + (OBI_AW'(count_d) << WORD_SHIFT);
  end

  always_ff @(posedge sys_clk) begin
    if (!sys_rstn) begin
      base_q  <= '0;
      count_q <= '0;
      wrap_q  <= '0;
      addr_q  <= '0;
    end else begin
      base_q  <= base_d;
      count_q <= count_d;
      wrap_q  <= wrap_d;
      addr_q  <= addr_d;
    end
  end

  assign addr = addr_q;
endmodule

// File: rtl/spi_slave_obi_master.sv
// SPI-slave-side OBI master: SPI burst commands become single-outstanding OBI word accesses.
// Optional saturating OBI error counter on err_count when SPI_OBI_ERR_CNT_EN is defined.
module spi_slave_obi_master
  import spi_obi_pkg::*;
(
  input  logic              sys_clk,
  input  logic              sys_rstn,
  input  logic              cs_end,
  input  logic [OBI_AW-1:0] ctrl_addr,
  input  logic              ctrl_addr_valid,
  input  logic              ctrl_rd_wr,
  input  logic [WRAP_W-1:0] wrap_length,
  input  logic [OBI_DW-1:0] rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic [OBI_DW-1:0] tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic              busy,
  spi_slave_obi_master_if.master obi
`ifdef SPI_OBI_ERR_CNT_EN
  ,
  output logic [7:0]        err_count
`endif
);
  state_e            state_q, state_d;
  logic              abort_q, abort_d, abort_c;
  logic [OBI_DW-1:0] wdata_q, wdata_d;
  logic [OBI_DW-1:0] tx_data_q, tx_data_d;
  logic              tx_valid_q, tx_valid_d;
  logic              req_q, req_d;
  logic              we_q, we_d;
  logic              busy_q, busy_d;
  logic              rx_ready_q, rx_ready_d;
  logic              ag_load, ag_advance;

  // A chip-select end seen during a bus access is only acted on once the access completes.
  assign abort_c = abort_q | cs_end;

  always_comb begin
    state_d    = state_q;
    abort_d    = abort_q;
    wdata_d    = wdata_q;
    tx_data_d  = tx_data_q;
    tx_valid_d = tx_valid_q;
    ag_load    = 1'b0;
    ag_advance = 1'b0;
    unique case (state_q)
      IDLE: begin
        tx_valid_d = 1'b0;
        if (!cs_end && ctrl_addr_valid) begin
          ag_load = 1'b1;
          state_d = ctrl_rd_wr ? RD_REQ : WR_WAIT;
        end
      end
      WR_WAIT: begin
        if (cs_end) begin
          state_d = IDLE;
        end else if (rx_valid) begin
          wdata_d = rx_data;
          state_d = WR_REQ;
        end
      end
      WR_REQ, RD_REQ: begin
        abort_d = abort_c;
        if (obi.obi_gnt) state_d = (state_q == WR_REQ) ? WR_RESP : RD_RESP;
      end
      WR_RESP: begin
        abort_d = abort_c;
        if (obi.obi_rvalid) begin
          ag_advance = 1'b1;
          abort_d    = 1'b0;
          state_d    = abort_c ? IDLE : WR_WAIT;
        end
      end
      RD_RESP: begin
        abort_d = abort_c;
        if (obi.obi_rvalid) begin
          abort_d = 1'b0;
          if (abort_c) begin
            state_d = IDLE;
          end else begin
            tx_data_d  = obi.obi_rdata;
            tx_valid_d = 1'b1;
            state_d    = RD_HOLD;
          end
        end
      end
      RD_HOLD: begin
        if (cs_end) begin
          tx_valid_d = 1'b0;
          state_d    = IDLE;
        end else if (tx_ready) begin
          tx_valid_d = 1'b0;
          ag_advance = 1'b1;
          state_d    = RD_REQ;
        end
      end
      default: state_d = IDLE;
    endcase
    // State-decoded outputs are registered from the next state so they align with state_q.
    req_d      = (state_d == WR_REQ) || (state_d == RD_REQ);
    we_d       = (state_d == WR_REQ);
    busy_d     = (state_d != IDLE);
    rx_ready_d = (state_d == WR_WAIT);
  end

  always_ff @(posedge sys_clk) begin
    if (!sys_rstn) begin
      state_q    <= IDLE;
      abort_q    <= 1'b0;
      wdata_q    <= '0;
      tx_data_q  <= '0;
      tx_valid_q <= 1'b0;
      req_q      <= 1'b0;
      we_q       <= 1'b0;
      busy_q     <= 1'b0;
      rx_ready_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      abort_q    <= abort_d;
      wdata_q    <= wdata_d;
      tx_data_q  <= tx_data_d;
      tx_valid_q <= tx_valid_d;
      req_q      <= req_d;
      we_q       <= we_d;
      busy_q     <= busy_d;
      rx_ready_q <= rx_ready_d;
    end
  end

  spi_obi_addr_gen u_addr_gen (
    .sys_clk    (sys_clk),
    .sys_rstn   (sys_rstn),
    .load       (ag_load),
    .advance    (ag_advance),
    .start_addr (ctrl_addr),
    .wrap_len   (wrap_length),
    .addr       (obi.obi_addr)
  );

  assign obi.obi_req   = req_q;
  assign obi.obi_we    = we_q;
  assign obi.obi_be    = {OBI_BEW{1'b1}};
  assign obi.obi_wdata = wdata_q;
  assign tx_data       = tx_data_q;
  assign tx_valid      = tx_valid_q;
  assign busy          = busy_q;
  assign rx_ready      = rx_ready_q;

`ifdef SPI_OBI_ERR_CNT_EN
  logic [7:0] err_cnt_q, err_cnt_d;

  always_comb begin
    err_cnt_d = err_cnt_q;
    if (obi.obi_rvalid && obi.obi_err && (err_cnt_q != 8'hFF)) err_cnt_d = err_cnt_q + 8'd1;
  end

  always_ff @(posedge sys_clk) begin
    if (!sys_rstn) err_cnt_q <= '0;
    else           err_cnt_q <= err_cnt_d;
  end

  assign err_count = err_cnt_q;
`else
  logic unused_err_c;
  assign unused_err_c = obi.obi_err;
`endif
endmodule

// File: tb/tb_spi_slave_obi_master.sv
// Self-checking bench: table-driven and random bursts against an address/data reference model.
module tb_spi_slave_obi_master;
  import spi_obi_pkg::*;

  logic        sys_clk = 1'b0;
  logic        sys_rstn, cs_end, ctrl_addr_valid, ctrl_rd_wr;
  logic [31:0] ctrl_addr, rx_data, tx_data;
  logic [15:0] wrap_length;
  logic        rx_valid, rx_ready, tx_valid, tx_ready, busy;
`ifdef SPI_OBI_ERR_CNT_EN
  logic [7:0]  err_count;
`endif

  spi_slave_obi_master_if obi();

  spi_slave_obi_master dut (
    .sys_clk         (sys_clk),
    .sys_rstn        (sys_rstn),
    .cs_end          (cs_end),
    .ctrl_addr       (ctrl_addr),
    .ctrl_addr_valid (ctrl_addr_valid),
    .ctrl_rd_wr      (ctrl_rd_wr),
    .wrap_length     (wrap_length),
    .rx_data         (rx_data),
    .rx_valid        (rx_valid),
    .rx_ready        (rx_ready),
    .tx_data         (tx_data),
    .tx_valid        (tx_valid),
    .tx_ready        (tx_ready),
    .busy            (busy),
    .obi             (obi)
`ifdef SPI_OBI_ERR_CNT_EN
    ,
    .err_count       (err_count)
`endif
  );

  always #5 sys_clk = ~sys_clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  // Reference model: word i of a burst lives at base + 4*(i mod wrap), or base + 4*i when wrap is 0.
  function automatic logic [31:0] model_addr(input logic [31:0] base, input int unsigned wrap,
                                             input int unsigned i);
    int unsigned k;
    k = (wrap == 0) ? i : (i % wrap);
    return base + 32'(k) * 32'd4;
  endfunction

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
  } txn_t;

  txn_t log_q[$];
  int   gnt_delay = 0;
  int   rsp_delay = 0;
  int   err_idx   = -1;
  int   rsp_count = 0;

  // OBI memory model: acts at #2 after each edge; the main thread drives and samples at #1.
  initial begin : responder
    bit          pending;
    int          wait_c, req_c;
    logic [31:0] held_addr, held_wdata, pend_addr;
    pending = 0; wait_c = 0; req_c = 0;
    held_addr = '0; held_wdata = '0; pend_addr = '0;
    obi.obi_gnt = 0; obi.obi_rvalid = 0; obi.obi_rdata = '0; obi.obi_err = 0;
    forever begin
      @(posedge sys_clk); #2;
      obi.obi_gnt = 0; obi.obi_rvalid = 0; obi.obi_err = 0;
      if (!sys_rstn) begin
        pending = 0; req_c = 0;
      end else if (pending) begin
        check("single_outstanding", 32'(obi.obi_req), 32'd0);
        if (wait_c == 0) begin
          obi.obi_rvalid = 1;
          obi.obi_rdata  = mem_word(pend_addr);
          obi.obi_err    = (rsp_count == err_idx);
          rsp_count++;
          pending = 0;
        end else wait_c--;
      end else if (obi.obi_req) begin
        if (req_c == 0) begin
          held_addr = obi.obi_addr; held_wdata = obi.obi_wdata;
        end else begin
          check("req_hold_addr", obi.obi_addr, held_addr);
          check("req_hold_wdata", obi.obi_wdata, held_wdata);
        end
        if (req_c >= gnt_delay) begin
          obi.obi_gnt = 1;
          check("obi_be", 32'(obi.obi_be), 32'hF);
          log_q.push_back('{obi.obi_addr, obi.obi_we, obi.obi_wdata});
          pend_addr = obi.obi_addr; pending = 1; wait_c = rsp_delay; req_c = 0;
        end else req_c++;
      end else if (req_c > 0) begin
        check("req_not_dropped", 32'(obi.obi_req), 32'd1);
        req_c = 0;
      end
    end
  end

  initial begin : watchdog
    #300000;
    $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge sys_clk); #1;
  endtask

  task automatic run_burst(input bit rd, input logic [31:0] base, input logic [15:0] wrap,
                           input int n, input int tx_dly, output logic [31:0] last_addr);
    logic [31:0] words[$];
    logic [31:0] w, exp_d;
    int c, exp_n;
    log_q.delete(); rsp_count = 0;
    ctrl_addr = base; wrap_length = wrap; ctrl_rd_wr = rd; ctrl_addr_valid = 1;
    tick;
    ctrl_addr_valid = 0; ctrl_addr = $urandom; wrap_length = 16'($urandom);
    check("busy_after_start", 32'(busy), 32'd1);
    if (!rd) begin
      for (int i = 0; i < n; i++) begin
        w = $urandom; words.push_back(w);
        rx_data = w; rx_valid = 1;
        c = 0;
        while (!rx_ready && c < 200) begin tick; c++; end
        check("rx_ready_wait", 32'(rx_ready), 32'd1);
        tick;
        rx_valid = 0; rx_data = $urandom;
      end
      c = 0;
      while (!rx_ready && c < 200) begin tick; c++; end
      check("wr_back_to_wait", 32'(rx_ready), 32'd1);
    end else begin
      for (int i = 0; i < n; i++) begin
        c = 0;
        while (!tx_valid && c < 200) begin tick; c++; end
        check("tx_valid_wait", 32'(tx_valid), 32'd1);
        exp_d = mem_word(model_addr(base, wrap, i));
        check($sformatf("tx_data[%0d]", i), tx_data, exp_d);
        for (int d = 0; d < tx_dly; d++) begin
          tick;
          check("tx_valid_hold", 32'(tx_valid), 32'd1);
          check("tx_data_hold", tx_data, exp_d);
        end
        tx_ready = 1;
        tick;
        tx_ready = 0;
        check("tx_valid_clear", 32'(tx_valid), 32'd0);
      end
    end
    cs_end = 1;
    tick;
    cs_end = 0;
    c = 0;
    while (busy && c < 200) begin
      check("no_tx_after_cs_end", 32'(tx_valid), 32'd0);
      tick; c++;
    end
    check("idle_after_cs_end", 32'(busy), 32'd0);
    // Reads leave one prefetched access that is completed and discarded.
    exp_n = rd ? n + 1 : n;
    check("txn_count", 32'(log_q.size()), 32'(exp_n));
    for (int i = 0; i < exp_n && i < log_q.size(); i++) begin
      check($sformatf("addr[%0d]", i), log_q[i].addr, model_addr(base, wrap, i));
      check($sformatf("we[%0d]", i), 32'(log_q[i].we), 32'(!rd));
      if (!rd) check($sformatf("wdata[%0d]", i), log_q[i].wdata, words[i]);
    end
    last_addr = (log_q.size() >= n) ? log_q[n-1].addr : 32'hDEAD_BEEF;
  endtask

  typedef struct {
    bit          rd;
    logic [31:0] base;
    logic [15:0] wrap;
    int          n;
    int          gd;
    int          rspd;
    int          txd;
    logic [31:0] exp_last;
  } vec_t;

  vec_t vecs[6];

  initial begin : main
    logic [31:0] last;
    int c;
`ifdef SPI_OBI_ERR_CNT_EN
    logic [7:0] ec0;
`endif
    vecs[0] = '{1'b0, 32'h0000_1000, 16'd0, 3, 0, 0, 0, 32'h0000_1008};
    vecs[1] = '{1'b1, 32'h0000_2000, 16'd4, 6, 0, 0, 0, 32'h0000_2004};
    vecs[2] = '{1'b1, 32'h0000_3000, 16'd0, 2, 5, 0, 3, 32'h0000_3004};
    vecs[3] = '{1'b0, 32'hFFFF_FFF8, 16'd0, 3, 1, 1, 0, 32'h0000_0000};
    vecs[4] = '{1'b1, 32'h0000_4000, 16'd1, 3, 0, 2, 1, 32'h0000_4000};
    vecs[5] = '{1'b0, 32'h0000_5010, 16'd3, 5, 0, 2, 0, 32'h0000_5014};

    sys_rstn = 0; cs_end = 0; ctrl_addr = '0; ctrl_addr_valid = 0; ctrl_rd_wr = 0;
    wrap_length = '0; rx_data = '0; rx_valid = 0; tx_ready = 0;
    repeat (3) tick;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_obi_req", 32'(obi.obi_req), 32'd0);
    check("rst_obi_addr", obi.obi_addr, 32'd0);
    check("rst_obi_be", 32'(obi.obi_be), 32'hF);
    check("rst_rx_ready", 32'(rx_ready), 32'd0);
    check("rst_tx_valid", 32'(tx_valid), 32'd0);
    sys_rstn = 1;
    tick;

    foreach (vecs[v]) begin
      gnt_delay = vecs[v].gd; rsp_delay = vecs[v].rspd;
      run_burst(vecs[v].rd, vecs[v].base, vecs[v].wrap, vecs[v].n, vecs[v].txd, last);
      check($sformatf("vec%0d_last_addr", v), last, vecs[v].exp_last);
      tick;
    end

    // obi_err on the second of three reads must not disturb the burst.
    gnt_delay = 0; rsp_delay = 0; err_idx = 1;
`ifdef SPI_OBI_ERR_CNT_EN
    ec0 = err_count;
`endif
    run_burst(1'b1, 32'h0000_8000, 16'd0, 3, 0, last);
    check("err_last_addr", last, 32'h0000_8008);
`ifdef SPI_OBI_ERR_CNT_EN
    check("err_count_delta", 32'(err_count - ec0), 32'd1);
`endif
    err_idx = -1;
    tick;

    // cs_end while the read response is pending: data dropped, idle right after rvalid.
    rsp_delay = 3; log_q.delete();
    ctrl_addr = 32'h0000_6000; wrap_length = '0; ctrl_rd_wr = 1; ctrl_addr_valid = 1;
    tick;
    ctrl_addr_valid = 0;
    c = 0;
    while (log_q.size() == 0 && c < 50) begin tick; c++; end
    check("abort_granted", 32'(log_q.size()), 32'd1);
    cs_end = 1;
    tick;
    cs_end = 0;
    c = 0;
    while (!obi.obi_rvalid && c < 50) begin
      check("abort_no_tx_valid", 32'(tx_valid), 32'd0);
      tick; c++;
    end
    check("abort_rvalid_seen", 32'(obi.obi_rvalid), 32'd1);
    check("abort_idle_after_rvalid", 32'(busy), 32'd0);
    check("abort_tx_valid", 32'(tx_valid), 32'd0);
    tick;
    check("abort_no_new_req", 32'(log_q.size()), 32'd1);
    rsp_delay = 0;

    // Reset while stuck in WR_REQ.
    gnt_delay = 1000;
    ctrl_addr = 32'h0000_7000; ctrl_rd_wr = 0; ctrl_addr_valid = 1;
    tick;
    ctrl_addr_valid = 0;
    rx_data = 32'hCAFE_F00D; rx_valid = 1;
    tick;
    rx_valid = 0;
    check("wrreq_obi_req", 32'(obi.obi_req), 32'd1);
    check("wrreq_obi_we", 32'(obi.obi_we), 32'd1);
    check("wrreq_wdata", obi.obi_wdata, 32'hCAFE_F00D);
    check("wrreq_addr", obi.obi_addr, 32'h0000_7000);
    repeat (2) tick;
    sys_rstn = 0;
    tick;
    check("mrst_obi_req", 32'(obi.obi_req), 32'd0);
    check("mrst_obi_we", 32'(obi.obi_we), 32'd0);
    check("mrst_obi_addr", obi.obi_addr, 32'd0);
    check("mrst_obi_wdata", obi.obi_wdata, 32'd0);
    check("mrst_tx_data", tx_data, 32'd0);
    check("mrst_tx_valid", 32'(tx_valid), 32'd0);
    check("mrst_rx_ready", 32'(rx_ready), 32'd0);
    check("mrst_busy", 32'(busy), 32'd0);
    check("mrst_obi_be", 32'(obi.obi_be), 32'hF);
    sys_rstn = 1; gnt_delay = 0;
    tick;
    check("mrst_stays_idle", 32'(obi.obi_req), 32'd0);

    // cs_end wins over a simultaneous start strobe.
    ctrl_addr = 32'h0000_9000; ctrl_rd_wr = 1; ctrl_addr_valid = 1; cs_end = 1;
    tick;
    ctrl_addr_valid = 0; cs_end = 0;
    check("cs_win_busy", 32'(busy), 32'd0);
    tick;
    check("cs_win_busy2", 32'(busy), 32'd0);
    check("cs_win_no_req", 32'(obi.obi_req), 32'd0);

    // Randomized bursts against the reference model.
    for (int r = 0; r < 12; r++) begin
      gnt_delay = $urandom_range(0, 3);
      rsp_delay = $urandom_range(0, 3);
      run_burst(1'($urandom_range(0, 1)), $urandom, 16'($urandom_range(0, 5)),
                $urandom_range(1, 6), $urandom_range(0, 2), last);
      tick;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/spi_slave_obi_master.md
SPI_SLAVE_OBI_MASTER -- requirements
Module: spi_slave_obi_master

Interface
REQ-001 Clock and reset SHALL be sys_clk (single clock) and sys_rstn, synchronous and active-low.
REQ-002 Ports SHALL be as follows (name, direction, width, meaning):
- sys_clk  in  1  system clock.
- sys_rstn  in  1  synchronous active-low reset.
- cs_end  in  1  SPI chip-select deasserted, already synchronized to sys_clk.
- ctrl_addr  in  32  start address.
- ctrl_addr_valid  in  1  one-cycle start strobe.
- ctrl_rd_wr  in  1  direction: 1 = read, 0 = write.
- wrap_length  in  16  burst wrap length in words; 0 = linear.
- rx_data  in  32  write data.
- rx_valid  in  1  write data valid.
- rx_ready  out  1  write data accepted.
- tx_data  out  32  read data.
- tx_valid  out  1  read data valid.
- tx_ready  in  1  read data accepted.
- obi_req  out  1  OBI request.
- obi_gnt  in  1  OBI grant.
- obi_addr  out  32  OBI address.
- obi_we  out  1  OBI write enable.
- obi_be  out  4  OBI byte enables.
- obi_wdata  out  32  OBI write data.
- obi_rvalid  in  1  OBI response valid.
- obi_rdata  in  32  OBI read data.
- obi_err  in  1  OBI error response.
- busy  out  1  burst active.

Function
REQ-003 The FSM SHALL have the states IDLE, WR_WAIT, WR_REQ, WR_RESP, RD_REQ, RD_RESP and RD_HOLD; busy SHALL be 1 in every state except IDLE.
REQ-004 In IDLE, ctrl_addr_valid SHALL latch ctrl_addr as the base address, clear the word count and latch wrap_length; the next state SHALL be RD_REQ if ctrl_rd_wr=1, otherwise WR_WAIT.
REQ-005 ctrl_addr_valid SHALL be ignored outside IDLE.
REQ-006 In WR_WAIT, rx_ready SHALL be 1 combinationally; rx_valid=1 SHALL capture rx_data into obi_wdata and move to WR_REQ.
REQ-007 In WR_REQ and RD_REQ, obi_req SHALL be 1, with obi_addr, obi_we and obi_wdata stable, until obi_gnt=1; the grant cycle SHALL move to WR_RESP or RD_RESP respectively.
REQ-008 obi_we SHALL be 1 only in WR_REQ, and obi_be SHALL be 4'hF in all cases.
REQ-009 WR_RESP SHALL wait for obi_rvalid, then advance the address and return to WR_WAIT.
REQ-010 RD_RESP SHALL wait for obi_rvalid, register obi_rdata into tx_data, set tx_valid=1 and move to RD_HOLD.
REQ-011 In RD_HOLD, tx_data and tx_valid SHALL be held until tx_ready=1; that cycle SHALL clear tx_valid, advance the address and return to RD_REQ (prefetch of the next word).
REQ-012 Only one OBI transaction SHALL be outstanding at any time.
REQ-013 Address SHALL be obi_addr = base + 4*count, taken modulo 2^32.
REQ-014 Address advance SHALL set count to 0 if wrap_length != 0 and count = wrap_length-1; otherwise count SHALL increment.
REQ-015 In IDLE, WR_WAIT or RD_HOLD, cs_end=1 SHALL move to IDLE on the next cycle and clear tx_valid.
REQ-016 In REQ or RESP states, cs_end=1 SHALL be remembered and the OBI transaction completed (obi_req is never dropped before obi_gnt); read data SHALL then be discarded (tx_valid stays 0) and the FSM SHALL enter IDLE.
REQ-017 If cs_end and ctrl_addr_valid are 1 in the same cycle, cs_end SHALL win and no burst SHALL start.
REQ-018 obi_err=1 with obi_rvalid SHALL NOT stop the burst: read data SHALL be forwarded unchanged and the address SHALL advance as usual.

Reset
REQ-019 With sys_rstn=0 at a clock edge, the state SHALL become IDLE and the following SHALL be 0: obi_req, obi_we, obi_addr, obi_wdata, tx_data, tx_valid, rx_ready, busy, count and the stored cs_end flag. obi_be SHALL still be 4'hF.
REQ-020 Reset mid-transaction SHALL abandon the bus transaction without waiting for obi_gnt or obi_rvalid.

Configuration
REQ-021 With SPI_OBI_ERR_CNT_EN defined, an output err_count [7:0] SHALL count obi_rvalid&obi_err cycles, saturate at 8'hFF and be cleared only by reset.
REQ-022 Without SPI_OBI_ERR_CNT_EN, the err_count port and its logic SHALL be absent; all other behaviour SHALL be identical.

Structure
REQ-023 A shared package spi_obi_pkg SHALL hold the FSM state enum, WORD_BYTES=4, OBI_AW=32 and OBI_DW=32.
REQ-024 A sub-module spi_obi_addr_gen SHALL hold the base/count/wrap registers and the advance logic (REQ-013, REQ-014).

Verification
REQ-025 Write burst: ctrl_addr=0x1000, rd_wr=0, wrap=0, three rx words, obi_gnt same cycle -> obi_addr 0x1000/0x1004/0x1008 with obi_we=1 and matching wdata.
REQ-026 Wrap: read at 0x2000, wrap_length=4, six words -> addresses 0x2000, 2004, 2008, 200C, 2000, 2004.
REQ-027 Backpressure: obi_gnt delayed 5 cycles and tx_ready delayed 3 cycles -> obi_req, obi_addr, tx_data and tx_valid held stable, with no second request issued.
REQ-028 Abort: cs_end during RD_RESP -> no tx_valid; IDLE one cycle after obi_rvalid; obi_req is never dropped before obi_gnt.
REQ-029 Error: obi_err on the 2nd of 3 reads -> burst continues, with err_count=1 when SPI_OBI_ERR_CNT_EN is defined.
REQ-030 Reset: sys_rstn low while in WR_REQ -> all REQ-019 values on the next edge; ctrl_addr_valid together with cs_end -> busy stays 0.
